// File: rtl/reg_file_pkg.sv
// reg_file_pkg -- shared sizing for the architectural register file.
//
// Holds the register-file geometry and the default ROB tag width.
// `ROB_LOG, `REG_LOG and `REG_NUM normally come from config.v. They are
// given fallback values here so the block also builds on its own.
//
// Optional feature macro (consumed by reg_file.sv): REGFILE_BYPASS_EN.

`ifndef ROB_LOG
`define ROB_LOG 4
`endif
`ifndef REG_LOG
`define REG_LOG 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

package reg_file_pkg;

  localparam int ROB_LOG_DEF = `ROB_LOG;  // ROB tag width
  localparam int REG_LOG     = `REG_LOG;  // register index width
  localparam int REG_NUM     = `REG_NUM;  // architectural registers
  localparam int XLEN        = 32;        // register value width

endpackage

// File: rtl/reg_file.sv
// reg_file -- architectural register file with rename tags.
//
// Issue marks a destination register busy with its ROB tag. Commit (the
// receiving end of the ROB commit port) writes the value. It releases the
// busy bit only while the committing tag is still the latest writer. A
// flush clears every pending tag. The two source queries are combinational.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a matching commit
// value to the queries in the same cycle. The default build has no bypass.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global ready; state holds while low
//   flush            ROB jump_flag; clears all busy bits, drops the issue
//   issue_valid      issue writes busy/tag of issue_rd
//   issue_rd         destination register index
//   issue_RobId      ROB tag allocated to the issuing instruction
//   commit_enable    ROB reg_enable
//   commit_index     ROB reg_index
//   commit_RobId     ROB reg_RobId
//   commit_value     ROB reg_value
//   query_rs1/rs2    source register indices
//   rsN_busy         source waits on a ROB entry
//   rsN_RobId        tag to wait on (0 when not busy)
//   rsN_value        register value (0 when busy)

module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG  = ROB_LOG_DEF,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,

  input  logic               issue_valid,
  input  logic [REG_LOG-1:0] issue_rd,
  input  logic [ROB_LOG-1:0] issue_RobId,

  input  logic               commit_enable,
  input  logic [REG_LOG-1:0] commit_index,
  input  logic [ROB_LOG-1:0] commit_RobId,
  input  logic [XLEN-1:0]    commit_value,

  input  logic [REG_LOG-1:0] query_rs1,
  input  logic [REG_LOG-1:0] query_rs2,

  output logic               rs1_busy,
  output logic [ROB_LOG-1:0] rs1_RobId,
  output logic [XLEN-1:0]    rs1_value,
  output logic               rs2_busy,
  output logic [ROB_LOG-1:0] rs2_RobId,
  output logic [XLEN-1:0]    rs2_value
);

  typedef struct packed {
    logic               busy;
    logic [ROB_LOG-1:0] rob_id;
    logic [XLEN-1:0]    value;
  } query_t;

  logic [XLEN-1:0]    val_q  [NUM_REGS];
  logic [ROB_LOG-1:0] tag_q  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;

  wire commit_hit = commit_enable && (commit_index != '0);
  wire issue_hit  = issue_valid && (issue_rd != '0);

  // ---------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------
  // NOTE: the value array is reset too, because a cleared register must
  // read as 0. A storage-only array without that need would skip the reset
  // and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy) begin
      // The commit value is written even on a flush. JAL/JALR raise
      // reg_enable and jump_flag together.
      if (commit_hit) begin
        val_q[commit_index] <= commit_value;
        // A stale tag means a younger writer is pending, so keep it busy.
        if (busy_q[commit_index] && (tag_q[commit_index] == commit_RobId))
          busy_q[commit_index] <= 1'b0;
      end

      // NOTE: non-blocking assignments let this later write override the
      // commit release above. That is how a same-cycle issue to the same
      // register wins busy and tag.
      if (flush) begin
        busy_q <= '0;
      end else if (issue_hit) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_RobId;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Combinational query path
  // ---------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  // Forwarding is valid only when the commit will really take effect.
  wire bypass_ok = rdy && !rst && commit_enable;
`endif

  function automatic query_t lookup(input logic [REG_LOG-1:0] r);
    query_t q;
    // NOTE: start from a full default so every path assigns every field.
    // That keeps the callers' always_comb free of latches.
    q = '0;
    if (r != '0) begin
      if (busy_q[r]) begin
`ifdef REGFILE_BYPASS_EN
        if (bypass_ok && (commit_index == r) && (commit_RobId == tag_q[r])) begin
          q.value = commit_value;
        end else begin
          q.busy   = 1'b1;
          q.rob_id = tag_q[r];
        end
`else
        q.busy   = 1'b1;
        q.rob_id = tag_q[r];
`endif
      end else begin
        q.value = val_q[r];
      end
    end
    return q;
  endfunction

  query_t rs1_q, rs2_q;

  always_comb begin
    rs1_q = lookup(query_rs1);
    rs2_q = lookup(query_rs2);
  end

  assign rs1_busy  = rs1_q.busy;
  assign rs1_RobId = rs1_q.rob_id;
  assign rs1_value = rs1_q.value;
  assign rs2_busy  = rs2_q.busy;
  assign rs2_RobId = rs2_q.rob_id;
  assign rs2_value = rs2_q.value;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file -- self-checking bench for reg_file.
// Expected query results are queued as stimulus is driven. They are popped
// and compared against the combinational outputs. Build with
// REGFILE_BYPASS_EN defined to check the bypass variant.

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_RobId;
  logic        commit_enable;
  logic [4:0]  commit_index;
  logic [3:0]  commit_RobId;
  logic [31:0] commit_value;
  logic [4:0]  query_rs1, query_rs2;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_RobId, rs2_RobId;
  logic [31:0] rs1_value, rs2_value;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          port;   // 0 = rs1, 1 = rs2
    logic        busy;
    logic [3:0]  rob_id;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file #(.ROB_LOG(4), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_RobId(issue_RobId),
    .commit_enable(commit_enable), .commit_index(commit_index),
    .commit_RobId(commit_RobId), .commit_value(commit_value),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_busy(rs1_busy), .rs1_RobId(rs1_RobId), .rs1_value(rs1_value),
    .rs2_busy(rs2_busy), .rs2_RobId(rs2_RobId), .rs2_value(rs2_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_q(input string tag, input bit port, input logic busy,
                          input logic [3:0] rob_id, input logic [31:0] value);
    exp_t e;
    e.tag = tag; e.port = port; e.busy = busy; e.rob_id = rob_id; e.value = value;
    sb.push_back(e);
  endtask

  // Let the combinational outputs settle, then compare every queued entry.
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port == 1'b0) begin
        check({e.tag, ".busy"},  {31'd0, rs1_busy},  {31'd0, e.busy});
        check({e.tag, ".robid"}, {28'd0, rs1_RobId}, {28'd0, e.rob_id});
        check({e.tag, ".value"}, rs1_value,          e.value);
      end else begin
        check({e.tag, ".busy"},  {31'd0, rs2_busy},  {31'd0, e.busy});
        check({e.tag, ".robid"}, {28'd0, rs2_RobId}, {28'd0, e.rob_id});
        check({e.tag, ".value"}, rs2_value,          e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_RobId = '0;
    commit_enable = 1'b0; commit_index = '0; commit_RobId = '0; commit_value = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] id);
    issue_valid = 1'b1; issue_rd = rd; issue_RobId = id;
  endtask

  task automatic commit(input logic [4:0] idx, input logic [3:0] id, input logic [31:0] v);
    commit_enable = 1'b1; commit_index = idx; commit_RobId = id; commit_value = v;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; query_rs1 = '0; query_rs2 = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    query_rs1 = 5'd5; query_rs2 = 5'd0;
    expect_q("reset_rs1", 0, 1'b0, 4'd0, 32'h0);
    expect_q("reset_rs2", 1, 1'b0, 4'd0, 32'h0);
    drain();

    // Issue then commit with a matching tag
    issue(5'd3, 4'd7); tick(); idle();
    query_rs1 = 5'd3;
    expect_q("issue3", 0, 1'b1, 4'd7, 32'h0);
    drain();
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    if (BYPASS) expect_q("commit3_same", 0, 1'b0, 4'd0, 32'hDEADBEEF);
    else        expect_q("commit3_same", 0, 1'b1, 4'd7, 32'h0);
    drain();
    tick(); idle();
    expect_q("commit3_next", 0, 1'b0, 4'd0, 32'hDEADBEEF);
    drain();

    // Stale commit: an older tag must not release a younger writer
    issue(5'd4, 4'd2); tick();
    issue(5'd4, 4'd9); tick(); idle();
    commit(5'd4, 4'd2, 32'h11);
    query_rs1 = 5'd4;
    expect_q("stale_same", 0, 1'b1, 4'd9, 32'h0);
    drain();
    tick(); idle();
    expect_q("stale_next", 0, 1'b1, 4'd9, 32'h0);
    drain();
    commit(5'd4, 4'd9, 32'h22); tick(); idle();
    expect_q("fresh4", 0, 1'b0, 4'd0, 32'h22);
    drain();

    // Same-cycle issue and commit to one register
    issue(5'd6, 4'd1); tick(); idle();
    issue(5'd6, 4'd5); commit(5'd6, 4'd1, 32'h33);
    query_rs2 = 5'd6;
    if (BYPASS) expect_q("same6_cyc", 1, 1'b0, 4'd0, 32'h33);
    else        expect_q("same6_cyc", 1, 1'b1, 4'd1, 32'h0);
    drain();
    tick(); idle();
    expect_q("same6_next", 1, 1'b1, 4'd5, 32'h0);
    drain();

    // Flush with a simultaneous commit and issue
    issue(5'd1, 4'd1); tick();
    issue(5'd2, 4'd2); tick();
    issue(5'd8, 4'd8); tick(); idle();
    query_rs1 = 5'd8; query_rs2 = 5'd2;
    expect_q("pre_flush8", 0, 1'b1, 4'd8, 32'h0);
    expect_q("pre_flush2", 1, 1'b1, 4'd2, 32'h0);
    drain();
    flush = 1'b1; commit(5'd1, 4'd1, 32'h44); issue(5'd10, 4'd3);
    tick(); idle();
    query_rs1 = 5'd1; query_rs2 = 5'd2;
    expect_q("flush_x1", 0, 1'b0, 4'd0, 32'h44);
    expect_q("flush_x2", 1, 1'b0, 4'd0, 32'h0);
    drain();
    query_rs1 = 5'd8; query_rs2 = 5'd10;
    expect_q("flush_x8",  0, 1'b0, 4'd0, 32'h0);
    expect_q("flush_x10", 1, 1'b0, 4'd0, 32'h0);
    drain();
    query_rs1 = 5'd6; query_rs2 = 5'd4;
    expect_q("flush_x6", 0, 1'b0, 4'd0, 32'h33);
    expect_q("flush_x4", 1, 1'b0, 4'd0, 32'h22);
    drain();

    // rdy low: issue, commit and flush are all ignored, bypass is suppressed
    issue(5'd12, 4'd12); tick(); idle();
    rdy = 1'b0;
    flush = 1'b1; issue(5'd7, 4'd6); commit(5'd9, 4'd0, 32'h55);
    tick(); idle();
    commit(5'd12, 4'd12, 32'h77);
    query_rs1 = 5'd12;
    expect_q("rdy0_nobyp", 0, 1'b1, 4'd12, 32'h0);
    drain();
    tick(); idle();
    rdy = 1'b1;
    query_rs1 = 5'd7; query_rs2 = 5'd9;
    expect_q("rdy0_x7", 0, 1'b0, 4'd0, 32'h0);
    expect_q("rdy0_x9", 1, 1'b0, 4'd0, 32'h0);
    drain();
    query_rs1 = 5'd12;
    expect_q("rdy0_x12", 0, 1'b1, 4'd12, 32'h0);
    drain();

    // x0 ignores issue and commit
    issue(5'd0, 4'd4); tick(); idle();
    commit(5'd0, 4'd0, 32'hFF); tick(); idle();
    query_rs1 = 5'd0; query_rs2 = 5'd0;
    expect_q("x0_rs1", 0, 1'b0, 4'd0, 32'h0);
    expect_q("x0_rs2", 1, 1'b0, 4'd0, 32'h0);
    drain();

    // Reset clears values and busy bits
    rst = 1'b1; tick(); rst = 1'b0;
    query_rs1 = 5'd3; query_rs2 = 5'd12;
    expect_q("rst2_x3",  0, 1'b0, 4'd0, 32'h0);
    expect_q("rst2_x12", 1, 1'b0, 4'd0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags; the receiving end of the ROB commit port.
- Issue marks a destination register busy with its ROB tag. Commit writes the value and releases the tag when it still matches.
- Issue queries rs1/rs2 combinationally and gets either a value or the ROB tag to wait on.
- A flush (branch mispredict or jump) clears every pending tag.

Parameters:
- ROB_LOG, default `ROB_LOG (4): width of ROB tags.
- NUM_REGS, default 32: architectural registers; index width is 5.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, state holds
- flush  in  1  ROB jump_flag; clears all busy bits
- issue_valid  in  1  an instruction with a destination register is issued this cycle
- issue_rd  in  5  destination register index
- issue_RobId  in  ROB_LOG  ROB tag allocated to the instruction
- commit_enable  in  1  ROB reg_enable
- commit_index  in  5  ROB reg_index
- commit_RobId  in  ROB_LOG  ROB reg_RobId
- commit_value  in  32  ROB reg_value
- query_rs1  in  5  source register 1 index
- query_rs2  in  5  source register 2 index
- rs1_busy  out  1  rs1 is waiting on a ROB entry
- rs1_RobId  out  ROB_LOG  tag to wait on; 0 when not busy
- rs1_value  out  32  register value; 0 when busy
- rs2_busy, rs2_RobId, rs2_value  out  1/ROB_LOG/32  same as rs1, for rs2

Behaviour:
- Reset (synchronous, active-high, when rst=1 at posedge): all 32 values = 0, all busy = 0, all tags = 0. Outputs are combinational, so after reset they read busy=0, RobId=0, value=0.
- rdy=0 with rst=0: no state changes; inputs are ignored, including flush.
- Query path is combinational, 0-cycle latency:
  - busy[r]=1: busy=1, RobId=tag[r], value=0.
  - busy[r]=0: busy=0, RobId=0, value=val[r].
  - r=0: always busy=0, value=0.
- Commit at posedge, when commit_enable=1 and commit_index≠0:
  - val[idx] <= commit_value.
  - If busy[idx]=1 and tag[idx]==commit_RobId, then busy[idx] <= 0.
  - If the tag does not match (a younger writer is pending), the value is still written and busy/tag are unchanged.
- Issue at posedge, when issue_valid=1 and issue_rd≠0 and flush=0: busy[rd] <= 1, tag[rd] <= issue_RobId.
- Issue and commit to the same register in one cycle: the issue wins busy and tag; the commit value is still written.
- flush=1: all busy <= 0 and the issue is ignored. A commit in the same cycle still writes its value, because the ROB asserts reg_enable and jump_flag together for JAL/JALR.
- Writes to x0 are always discarded.
- Latency: a commit becomes visible to queries in the following cycle, unless the bypass option below is enabled.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A query whose register is busy, with commit_enable=1, commit_index==query, and commit_RobId==tag, returns busy=0, RobId=0, value=commit_value in the same cycle.
  - Bypass is suppressed when rdy=0 or rst=1.
- Undefined: no bypass. The query shows busy until the cycle after commit; the issue stage then relies on the ROB ready/value query for that tag.

Decomposition:
- config.v already holds `ROB_LOG and `ROB_SIZE. Add `REG_LOG (5) and `REG_NUM (32) there.
- No sub-module. The two query ports are identical always-blocks, or a function inside the module.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> busy=0, value=0 on both.
- Issue rd=3 with RobId=7; next cycle query rs1=3 -> busy=1, RobId=7. Commit idx=3, RobId=7, value=0xDEADBEEF; next cycle -> busy=0, value=0xDEADBEEF. With bypass enabled, the value is already visible in the commit cycle.
- Stale commit:
  - Issue rd=4 with tag 2, then rd=4 with tag 9.
  - Commit idx=4, tag 2, value 0x11 -> busy=1, RobId=9.
  - Commit tag 9, value 0x22 -> busy=0, value=0x22.
- Same cycle: issue rd=6 with tag 5 and commit idx=6 (old tag 1), value 0x33 -> busy=1, RobId=5, val[6]=0x33.
- Flush:
  - Registers 1, 2 and 8 are busy.
  - flush=1 together with commit idx=1 (tag matches), value 0x44, and issue rd=10 with tag 3.
  - Next cycle: all registers busy=0, x1=0x44, x10 not busy.
- rdy=0 with issue rd=7 and commit idx=9 value 0x55 -> no change. Issue rd=0 with tag 4 under rdy=1 -> x0 stays busy=0, value=0.
